// File: rtl/mux_rr_n_if.sv
// mux_rr_n_if -- bundle of the channel-side and output-side handshake
// signals of the mux_rr_n round-robin/fixed-select multiplexer.
//
// Parameters:
//   WIDTH    data bits per channel
//   CHANNELS number of input channels
//   SELW     width of a channel index
//
// Signals:
//   in_data   CHANNELS*WIDTH  channel c in bits [c*WIDTH +: WIDTH]
//   in_valid  CHANNELS        per-channel data valid
//   in_ready  CHANNELS        per-channel accept strobe (from the mux)
//   mode      1               0 = fixed select, 1 = round-robin scan
//   sel       SELW            channel index used in fixed mode
//   out_data  WIDTH           registered selected data
//   out_chan  SELW            registered index of the supplying channel
//   out_valid 1               registered output valid
//   out_ready 1               downstream accept
//
// Modports: slave is the mux itself, master is whatever drives its
// channels and consumes its output.
interface mux_rr_n_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [SELW-1:0]           sel;
  logic [WIDTH-1:0]          out_data;
  logic [SELW-1:0]           out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_rr_n.sv
// mux_rr_n -- N-channel multiplexer with a one-beat registered output.
// In fixed mode it passes channel 'sel'; in round-robin mode it scans
// the valid channels starting at an internal pointer that advances past
// each channel it serves.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  mux_rr_n_if slave modport (channel inputs, ready strobes,
//        mode/sel controls, registered output beat and its handshake)
module mux_rr_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
) (
  input  logic       clk,
  input  logic       rst,
  mux_rr_n_if.slave  bus
);

  logic [SELW-1:0]     ptr;
  logic                load_en;
  logic                fx_found;
  logic [SELW-1:0]     fx_idx;
  logic                rr_found;
  logic [SELW-1:0]     rr_idx;
  logic                grant_found;
  logic [SELW-1:0]     grant_idx;
  logic [WIDTH-1:0]    grant_data;
  logic [CHANNELS-1:0] ready;
  logic [SELW-1:0]     next_ptr;

  // The output register can take a new beat when it is empty or its
  // current beat is being accepted this cycle.
  assign load_en = !bus.out_valid || bus.out_ready;

  // Fixed-mode grant. A sel at or beyond CHANNELS never matches any
  // loop index, so it simply yields no grant.
  always_comb begin
    fx_found = 1'b0;
    fx_idx   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(bus.sel) == c && bus.in_valid[c]) begin
        fx_found = 1'b1;
        fx_idx   = SELW'(c);
      end
    end
  end

  // Round-robin grant. The first loop finds the lowest valid channel,
  // which is the answer once the search has wrapped past the top. The
  // second loop finds the lowest valid channel at or above ptr and, if
  // one exists, overrides the wrapped answer.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (bus.in_valid[c]) begin
        rr_found = 1'b1;
        rr_idx   = SELW'(c);
      end
    end
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (bus.in_valid[c] && c >= int'(ptr)) begin
        rr_idx = SELW'(c);
      end
    end
  end

  // Final grant, the selected channel's data, and the ready strobe.
  // Ready is held low during reset so no transfer is ever signalled.
  always_comb begin
    grant_found = bus.mode ? rr_found : fx_found;
    grant_idx   = bus.mode ? rr_idx   : fx_idx;
    grant_data  = '0;
    ready       = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(grant_idx) == c) begin
        grant_data = bus.in_data[c*WIDTH +: WIDTH];
        ready[c]   = !rst && load_en && grant_found;
      end
    end
  end

  assign bus.in_ready = ready;

  // The pointer wraps explicitly so non-power-of-two channel counts
  // never leave it pointing at a channel that does not exist.
  assign next_ptr = (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + SELW'(1);

  // Output beat register and round-robin pointer. When the register is
  // free but nothing is granted the beat is dropped (valid falls) while
  // data and channel keep their last values. Fixed-mode transfers
  // leave the pointer alone so round-robin resumes where it stopped.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_chan  <= '0;
      ptr           <= '0;
    end else if (load_en) begin
      if (grant_found) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= grant_data;
        bus.out_chan  <= grant_idx;
        if (bus.mode) begin
          ptr <= next_ptr;
        end
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mux_rr_n.md
MUX_RR_N -- requirements
Module: mux_rr_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel (>=1).
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 SHALL have parameter SELW, default 2, select/channel-index width; SHALL satisfy 2**SELW >= CHANNELS.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  CHANNELS  per-channel data-valid.
REQ-008 SHALL have port in_ready  output  CHANNELS  per-channel accept strobe, combinational.
REQ-009 SHALL have port mode  input  1  0 = fixed select, 1 = round-robin scan.
REQ-010 SHALL have port sel  input  SELW  channel index used in fixed mode.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-012 SHALL have port out_chan  output  SELW  registered index of the channel that supplied out_data.
REQ-013 SHALL have port out_valid  output  1  registered output-valid.
REQ-014 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-015 SHALL define load_en = !out_valid || out_ready; output register loads only when load_en=1 and a grant exists.
REQ-016 Fixed mode: grant SHALL be channel sel when sel < CHANNELS and in_valid[sel]=1; otherwise no grant.
REQ-017 Round-robin mode: grant SHALL be the first c with in_valid[c]=1, searching ptr, ptr+1, ... wrapping modulo CHANNELS.
REQ-018 in_ready[c] SHALL be 1 only for the granted channel and only when load_en=1; at most one bit of in_ready high in any cycle.
REQ-019 Input transfer SHALL occur on in_valid[c] && in_ready[c]; on that edge out_data <= channel c data, out_chan <= c, out_valid <= 1 (latency: 1 cycle).
REQ-020 If load_en=1 and no grant, out_valid SHALL go 0 at the edge; out_data/out_chan SHALL hold.
REQ-021 If out_valid=1 and out_ready=0, out_data, out_chan, out_valid SHALL hold unchanged and all in_ready SHALL be 0.
REQ-022 Simultaneous out_ready=1 and new grant SHALL produce back-to-back transfers, one per cycle, no bubble.
REQ-023 ptr (SELW bits) SHALL update to (granted+1) mod CHANNELS on every round-robin transfer; wrap CHANNELS-1 -> 0 explicit (non-power-of-two CHANNELS).
REQ-024 ptr SHALL NOT change on fixed-mode transfers or cycles without transfer.
REQ-025 mode and sel changes SHALL take effect on the same cycle's grant decision; the held output beat SHALL be unaffected.
REQ-026 Switching fixed -> round-robin SHALL resume from the retained ptr value.

Reset
REQ-027 When rst=1 at a rising edge: out_valid <= 0, out_data <= 0, out_chan <= 0, ptr <= 0.
REQ-028 While rst=1, in_ready SHALL be all 0 and no transfer SHALL be recorded.
REQ-029 Reset asserted mid-stall SHALL discard the held beat; first grant after release SHALL start search at channel 0.

Verification
REQ-030 Fixed mode, sel=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_chan=2, out_valid=1.
REQ-031 Round-robin, all four in_valid=1 held, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
REQ-032 Round-robin, ptr=2, in_valid=4'b0011 -> grant ch0, ptr becomes 1; next grant ch1 (wrap check).
REQ-033 out_valid=1 with out_ready=0 for 3 cycles while inputs toggle -> out_data/out_chan constant, in_ready=0; out_ready=1 -> next queued beat loads same edge.
REQ-034 CHANNELS=3, fixed mode, sel=3 -> in_ready=0, out_valid falls to 0 after current beat is accepted.
REQ-035 rst=1 during stall with out_valid=1 -> next cycle out_valid=0, out_data=0, out_chan=0; round-robin with in_valid=4'b1001 after release -> grant ch0 first.
